// File: rtl/uart_program_loader.sv
// uart_program_loader: 8N1 UART receiver feeding a framed program-image decoder.
// Frame: A5, CNT_HI, CNT_LO, CNT x (hi, lo), CSUM = XOR of all bytes between sync and CSUM.
module uart_program_loader #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int MAX_WORDS      = 16384,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] programOut,
  output logic        prog_valid,
  output logic [14:0] word_index,
  output logic        LMout,
  output logic        load_done,
  output logic        load_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {L_IDLE, L_CNT_HI, L_CNT_LO, L_WD_HI, L_WD_LO, L_CSUM} ld_t;
  rx_t rx_state, rx_next;
  ld_t l_state, l_next;
  logic rx_m, rx_s, rx_p;
  logic [CW-1:0] bit_clk;
  logic [2:0] bit_num;
  logic [7:0] shift, cnt_hi, hi, csum;
  logic [15:0] count, cnt_val;
  logic [TW-1:0] tmo;
  logic bit_end, byte_stb, frame_err, tmo_hit, last, do_err, do_done;
  assign bit_end = bit_clk == CW'(CLKS_PER_BIT - 1);
  assign cnt_val = {cnt_hi, shift};
  assign last    = {1'b0, word_index} + 16'd1 == count;
  assign tmo_hit = l_state != L_IDLE && !byte_stb && tmo == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    rx_next   = rx_state;
    byte_stb  = 1'b0;
    frame_err = 1'b0;
    case (rx_state)
      RX_IDLE:  rx_next = rx_p && !rx_s ? RX_START : RX_IDLE;
      RX_START: if (bit_clk == CW'(CLKS_PER_BIT / 2 - 1)) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_num == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_end) begin
        rx_next   = RX_IDLE;
        byte_stb  = rx_s;
        frame_err = !rx_s;
      end
      default:  rx_next = RX_IDLE;
    endcase
  end
  // Sync flops start high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_state <= RX_IDLE;
      {rx_m, rx_s, rx_p} <= 3'b111;
      bit_clk <= '0;
      bit_num <= '0;
      shift <= '0;
    end else begin
      rx_state <= rx_next;
      {rx_m, rx_s, rx_p} <= {rx, rx_m, rx_s};
      bit_clk <= (rx_state != rx_next || bit_end) ? '0 : bit_clk + 1'b1;
      if (rx_state == RX_DATA && bit_end) begin
        shift <= {rx_s, shift[7:1]};
        bit_num <= bit_num + 1'b1;
      end
    end
  always_comb begin
    l_next  = l_state;
    do_err  = 1'b0;
    do_done = 1'b0;
    if (l_state != L_IDLE && (frame_err || tmo_hit)) begin
      do_err = 1'b1;
      l_next = L_IDLE;
    end else if (byte_stb)
      case (l_state)
        L_IDLE:   l_next = shift == 8'hA5 ? L_CNT_HI : L_IDLE;
        L_CNT_HI: l_next = L_CNT_LO;
        L_CNT_LO: begin
          do_err = cnt_val > 16'(MAX_WORDS);
          l_next = do_err ? L_IDLE : cnt_val == 16'd0 ? L_CSUM : L_WD_HI;
        end
        L_WD_HI:  l_next = L_WD_LO;
        L_WD_LO:  l_next = last ? L_CSUM : L_WD_HI;
        L_CSUM: begin
          do_done = shift == csum;
          do_err  = !do_done;
          l_next  = L_IDLE;
        end
        default:  l_next = L_IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      l_state <= L_IDLE;
      programOut <= '0;
      prog_valid <= 1'b0;
      word_index <= '0;
      LMout <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
      cnt_hi <= '0;
      count <= '0;
      hi <= '0;
      csum <= '0;
      tmo <= '0;
    end else begin
      l_state <= l_next;
      prog_valid <= 1'b0;
      load_done <= 1'b0;
      tmo <= (l_state == L_IDLE || byte_stb) ? '0 : tmo + 1'b1;
      if (prog_valid) word_index <= word_index + 1'b1;
      if (do_err) begin
        load_err <= 1'b1;
        LMout <= 1'b0;
      end
      if (do_done) begin
        load_done <= 1'b1;
        LMout <= 1'b0;
      end
      if (byte_stb && l_state != L_IDLE) csum <= csum ^ shift;
      if (byte_stb)
        case (l_state)
          L_IDLE: if (shift == 8'hA5) begin
            LMout <= 1'b1;
            load_err <= 1'b0;
            word_index <= '0;
            csum <= '0;
          end
          L_CNT_HI: cnt_hi <= shift;
          L_CNT_LO: count <= cnt_val;
          L_WD_HI:  hi <= shift;
          L_WD_LO: begin
            programOut <= {hi, shift};
            prog_valid <= 1'b1;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed frames with a word scoreboard checked on prog_valid.
module tb_uart_program_loader;
  localparam int CPB = 16;
  localparam int TO  = 4000;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1;
  logic [15:0] programOut;
  logic prog_valid, LMout, load_done, load_err;
  logic [14:0] word_index;
  logic [30:0] exp_q[$];
  logic [30:0] e;
  int total = 0, bad = 0, done_cnt = 0;
  uart_program_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(16384), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx(rx), .programOut(programOut), .prog_valid(prog_valid),
    .word_index(word_index), .LMout(LMout), .load_done(load_done), .load_err(load_err));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (prog_valid) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL extra_word: got=%h@%0d exp=none", programOut, word_index);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert ({word_index, programOut} === e) else begin
          bad++;
          $error("FAIL word: got=%h@%0d exp=%h@%0d", programOut, word_index, e[15:0], e[30:16]);
        end
      end
    end
    if (load_done) begin
      done_cnt++;
      total++;
      assert (LMout === 1'b0 && prog_valid === 1'b0) else begin
        bad++;
        $error("FAIL done_flags: got LM=%b pv=%b exp LM=0 pv=0", LMout, prog_valid);
      end
    end
  end
  initial begin
    idle(4);
    chk("rst_out", programOut, 0);
    chk("rst_pv", prog_valid, 0);
    chk("rst_idx", word_index, 0);
    chk("rst_lm", LMout, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    reset = 1'b0;
    idle(4);
    // good two-word frame
    exp_q.push_back({15'd0, 16'h1234});
    exp_q.push_back({15'd1, 16'hBEEF});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    @(negedge clk);
    chk("t1_lm_on", LMout, 1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h75);
    idle(4);
    chk("t1_done", done_cnt, 1);
    chk("t1_err", load_err, 0);
    chk("t1_lm_off", LMout, 0);
    chk("t1_q", exp_q.size(), 0);
    // bad checksum
    exp_q.push_back({15'd0, 16'h1234});
    exp_q.push_back({15'd1, 16'hBEEF});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h76);
    idle(4);
    chk("t2_err", load_err, 1);
    chk("t2_done", done_cnt, 1);
    chk("t2_q", exp_q.size(), 0);
    // framing error on 4th byte, then recovery
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    @(negedge clk);
    chk("t3_err_clr", load_err, 0);
    chk("t3_lm_on", LMout, 1);
    send_byte(8'h34, 1'b0);
    idle(4 * CPB);
    chk("t3_err", load_err, 1);
    chk("t3_lm_off", LMout, 0);
    exp_q.push_back({15'd0, 16'h1234});
    exp_q.push_back({15'd1, 16'hBEEF});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h75);
    idle(4);
    chk("t3_done", done_cnt, 2);
    chk("t3_err_ok", load_err, 0);
    // glitch and noise bytes before sync
    rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    rx = 1'b1;
    idle(2 * CPB);
    chk("t4_lm", LMout, 0);
    exp_q.push_back({15'd0, 16'hABCD});
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h67);
    idle(4);
    chk("t4_done", done_cnt, 3);
    chk("t4_err", load_err, 0);
    // count overflow, then empty frame
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h01);
    @(negedge clk);
    chk("t5_ovf_err", load_err, 1);
    chk("t5_ovf_lm", LMout, 0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(4);
    chk("t5_empty_done", done_cnt, 4);
    chk("t5_empty_err", load_err, 0);
    // count == MAX_WORDS accepted; reset mid-word
    exp_q.push_back({15'd0, 16'h1234});
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
    @(negedge clk);
    chk("t6_max_err", load_err, 0);
    chk("t6_max_lm", LMout, 1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    @(negedge clk);
    chk("t6_idx", word_index, 1);
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_lm", LMout, 0);
    chk("t6_rst_idx", word_index, 0);
    chk("t6_rst_out", programOut, 0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    reset = 1'b0;
    idle(12 * CPB);
    chk("t6_rst_done", done_cnt, 4);
    chk("t6_rst_err", load_err, 0);
    // timeout inside a frame
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    idle(TO - 100);
    chk("t6_pre_to_err", load_err, 0);
    chk("t6_pre_to_lm", LMout, 1);
    idle(200);
    chk("t6_to_err", load_err, 1);
    chk("t6_to_lm", LMout, 0);
    chk("final_q", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
